// File: rtl/wb_apb_pkg.sv
// Shared types and constants for the Wishbone-classic to APB3 bridge.
// Holds the bridge FSM state encoding and the read data returned when an
// APB access is terminated by the optional timeout (APB_TIMEOUT_EN).
package wb_apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} bridge_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_apb_bridge.sv
// Wishbone-classic slave to APB3 master bridge, one outstanding transfer.
// Each Wishbone single read/write becomes one APB SETUP/ACCESS transfer and
// completes with a one-cycle s_ack (plus apb_err on pslverr).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_cyc/s_stb/s_we/s_adr/s_wdata   Wishbone request
//   s_rdata/s_ack/apb_err      Wishbone response (registered)
//   paddr/psel/penable/pwrite/pwdata APB master outputs (registered)
//   prdata/pready/pslverr      APB slave response
//
// Optional: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles; on expiry the transfer ends with apb_err=1 and,
// for reads, s_rdata=TIMEOUT_RDATA.
module wb_apb_bridge
  import wb_apb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int APB_AW         = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_cyc,
  input  logic              s_stb,
  input  logic              s_we,
  input  logic [AW-1:0]     s_adr,
  input  logic [DW-1:0]     s_wdata,
  output logic [DW-1:0]     s_rdata,
  output logic              s_ack,
  output logic              apb_err,
  output logic [APB_AW-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  bridge_state_t state;
  logic          abort;
  logic          aborted;

  // A master that drops s_cyc on the completing cycle itself is treated
  // as aborted too, so the response is never presented to a gone master.
  assign aborted = abort | ~s_cyc;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  logic unused_ok;
  assign unused_ok = ^s_adr[AW-1:APB_AW];
`else
  logic unused_ok;
  assign unused_ok = ^{s_adr[AW-1:APB_AW], TIMEOUT_CYCLES[0]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      abort   <= 1'b0;
      s_ack   <= 1'b0;
      s_rdata <= '0;
      apb_err <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      // s_ack/apb_err are single-cycle pulses raised only on ACCESS exit
      s_ack   <= 1'b0;
      apb_err <= 1'b0;
      case (state)
        IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (s_cyc && s_stb) begin
            paddr  <= s_adr[APB_AW-1:0];
            pwrite <= s_we;
            pwdata <= s_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          if (!s_cyc) abort <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          if (!s_cyc) abort <= 1'b1;
          if (pready) begin
            if (!pwrite) s_rdata <= prdata;
            s_ack   <= ~aborted;
            apb_err <= pslverr & ~aborted;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_hit) begin
            if (!pwrite) s_rdata <= TIMEOUT_RDATA;
            s_ack   <= ~aborted;
            apb_err <= ~aborted;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          abort <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Self-checking bench for wb_apb_bridge: a Wishbone master driver, a simple
// APB slave with programmable wait/error, and two scoreboards (expected APB
// transfers and expected Wishbone responses).
module tb_wb_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdata, s_rdata;
  logic        s_ack, apb_err;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  wb_apb_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .apb_err(apb_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct { logic [15:0] addr; logic we; logic [31:0] wdata; } apb_exp_t;
  typedef struct { logic [31:0] rdata; logic err; } wb_exp_t;

  apb_exp_t apb_q[$];
  wb_exp_t  wb_q[$];

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc_n = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic [31:0] last_rd = '0;
  logic        ack_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Expected results are recorded as each request is issued.
  task automatic push_exp(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic err);
    apb_exp_t a;
    wb_exp_t  w;
    a.addr = adr[15:0]; a.we = we; a.wdata = wd;
    apb_q.push_back(a);
    if (!we) last_rd = rd;
    w.rdata = last_rd; w.err = err;
    wb_q.push_back(w);
  endtask

  // APB slave: asserts pready after slv_wait ACCESS cycles.
  initial begin
    int wcnt;
    apb_exp_t e;
    pready = 1'b0; prdata = '0; pslverr = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        if (wcnt >= slv_wait) begin
          pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
          if (apb_q.size() == 0) check("apb_unexpected", psel, 1'b0);
          else begin
            e = apb_q.pop_front();
            check("paddr", paddr, e.addr);
            check("pwrite", pwrite, e.we);
            if (e.we) check("pwdata", pwdata, e.wdata);
          end
        end else pready = 1'b0;
        wcnt++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; wcnt = 0;
      end
    end
  end

  // Wishbone response monitor.
  always @(negedge clk) begin
    wb_exp_t w;
    if (ack_d) begin
      check("ack_pulse", s_ack, 1'b0);
      check("err_pulse", apb_err, 1'b0);
    end
    if (s_ack) begin
      if (wb_q.size() == 0) check("ack_unexpected", s_ack, 1'b0);
      else begin
        w = wb_q.pop_front();
        check("s_rdata", s_rdata, w.rdata);
        check("apb_err", apb_err, w.err);
      end
    end
    ack_d <= s_ack;
  end

  // Called at a negedge; returns at the negedge where s_ack is seen.
  task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input int bound, output int lat);
    int t0;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_wdata = wd;
    t0 = cyc_n;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (s_ack) break;
    end
    if (!s_ack) check("ack_timeout", s_ack, 1'b1);
    lat = cyc_n - t0;
    s_cyc = 1'b0; s_stb = 1'b0;
  endtask

  initial begin
    int lat, c1, c2;
    rst_n = 1'b0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_ack", s_ack, 1'b0);
    check("rst_err", apb_err, 1'b0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_paddr", paddr, 16'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pwrite", pwrite, 1'b0);

    // zero-wait write with cycle-by-cycle APB phase checks
    slv_wait = 0;
    push_exp(1'b1, 32'h1000_0010, 32'hA5A5_1234, 32'h0, 1'b0);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'h1000_0010; s_wdata = 32'hA5A5_1234;
    @(negedge clk);
    check("w_setup_psel", psel, 1'b1);
    check("w_setup_penable", penable, 1'b0);
    @(negedge clk);
    check("w_acc_penable", penable, 1'b1);
    check("w_acc_paddr", paddr, 16'h0010);
    check("w_acc_pwrite", pwrite, 1'b1);
    check("w_acc_pwdata", pwdata, 32'hA5A5_1234);
    @(negedge clk);
    check("w_ack", s_ack, 1'b1);
    check("w_err", apb_err, 1'b0);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    check("w_ack_clear", s_ack, 1'b0);

    // read with 3 wait states
    slv_wait = 3; slv_rdata = 32'hCAFE_0001;
    push_exp(1'b0, 32'h1000_0004, 32'h0, 32'hCAFE_0001, 1'b0);
    wb_req(1'b0, 32'h1000_0004, 32'h0, 50, lat);
    check("rd_wait_latency", lat, 6);
    @(negedge clk);

    // read terminated by pslverr
    slv_wait = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b1;
    push_exp(1'b0, 32'h1000_0008, 32'h0, 32'h1234_5678, 1'b1);
    wb_req(1'b0, 32'h1000_0008, 32'h0, 50, lat);
    check("rd_err_latency", lat, 3);
    @(negedge clk);
    slv_err = 1'b0;

    // master abort during ACCESS: APB completes, no ack
    slv_wait = 3; slv_rdata = 32'h5555_AAAA;
    begin
      apb_exp_t a;
      a.addr = 16'h0020; a.we = 1'b0; a.wdata = '0;
      apb_q.push_back(a);
    end
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h1000_0020;
    repeat (2) @(negedge clk);
    s_cyc = 1'b0; s_stb = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_apb_done", apb_q.size(), 0);
    last_rd = 32'h5555_AAAA;
    slv_wait = 0; slv_rdata = 32'h0BAD_F00D;
    push_exp(1'b0, 32'h1000_0024, 32'h0, 32'h0BAD_F00D, 1'b0);
    wb_req(1'b0, 32'h1000_0024, 32'h0, 50, lat);
    check("post_abort_latency", lat, 3);
    @(negedge clk);

    // back-to-back writes, stb held across both
    push_exp(1'b1, 32'h1000_0030, 32'h1111_2222, 32'h0, 1'b0);
    push_exp(1'b1, 32'h1000_0034, 32'h3333_4444, 32'h0, 1'b0);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'h1000_0030; s_wdata = 32'h1111_2222;
    c1 = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_ack) break; end
    check("b2b_ack1", s_ack, 1'b1);
    c1 = cyc_n;
    s_adr = 32'h1000_0034; s_wdata = 32'h3333_4444;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_ack) break; end
    check("b2b_ack2", s_ack, 1'b1);
    c2 = cyc_n;
    s_cyc = 1'b0; s_stb = 1'b0;
    check("b2b_spacing", c2 - c1, 4);
    @(negedge clk);

    // reset while stuck in ACCESS
    slv_wait = 100000;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h1000_0040;
    repeat (4) @(negedge clk);
    check("pre_rst_psel", psel, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_psel", psel, 1'b0);
    check("midrst_penable", penable, 1'b0);
    check("midrst_ack", s_ack, 1'b0);
    check("midrst_rdata", s_rdata, 32'h0);
    s_cyc = 1'b0; s_stb = 1'b0;
    rst_n = 1'b1;
    last_rd = 32'h0;
    slv_wait = 0;
    @(negedge clk);
    slv_rdata = 32'h7777_0042;
    push_exp(1'b0, 32'h1000_0044, 32'h0, 32'h7777_0042, 1'b0);
    wb_req(1'b0, 32'h1000_0044, 32'h0, 50, lat);
    check("post_rst_latency", lat, 3);
    @(negedge clk);

`ifdef APB_TIMEOUT_EN
    // ACCESS timeout on a read with pready stuck low
    slv_wait = 100000;
    begin
      wb_exp_t w;
      w.rdata = 32'hDEAD_BEEF; w.err = 1'b1;
      wb_q.push_back(w);
    end
    last_rd = 32'hDEAD_BEEF;
    wb_req(1'b0, 32'h1000_0050, 32'h0, 400, lat);
    check("timeout_latency", lat, 258);
    check("timeout_psel", psel, 1'b0);
    slv_wait = 0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("wb_q_empty", wb_q.size(), 0);
    check("apb_q_empty", apb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
